// File: rtl/jtag_tap_master.sv
// JTAG initiator: divides iclk into tck, sequences tms/tdi for TAP reset,
// IR/DR scans and idle clocks, and returns the bits captured from tdo.
module jtag_tap_master #(
    parameter int DW      = 32,
    parameter int CLK_DIV = 2
) (
    input  logic                iclk,
    input  logic                ireset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [$clog2(DW):0] cmd_len,
    input  logic [DW-1:0]       cmd_data,
    output logic                rsp_valid,
    output logic [DW-1:0]       rsp_data,
    output logic                busy,
    output logic                tck,
    output logic                tms,
    output logic                tdi,
    input  logic                tdo
);
    localparam int LW   = $clog2(DW) + 1;
    localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);
    localparam logic [DIVW-1:0] DIV_ONE  = DIVW'(1);
    localparam logic [LW-1:0]   ONE      = LW'(1);
    localparam logic [LW-1:0]   LEN_MAX  = LW'(DW);

    localparam logic [2:0] RST_SEQ = 3'd0;
    localparam logic [2:0] IDLE    = 3'd1;
    localparam logic [2:0] HDR     = 3'd2;
    localparam logic [2:0] SHIFT   = 3'd3;
    localparam logic [2:0] TRL     = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    localparam logic [1:0] OP_RST  = 2'b00;
    localparam logic [1:0] OP_IR   = 2'b01;
    localparam logic [1:0] OP_IDLE = 2'b11;

    logic [2:0]      state;
    logic [1:0]      op_q;
    logic [LW-1:0]   len_q;
    logic [LW-1:0]   idx;
    logic [LW-1:0]   nxt;
    logic [LW-1:0]   hdr_n;
    logic [LW-1:0]   rsh;
    logic [DW-1:0]   sh_q;
    logic [DW-1:0]   cap;
    logic [DIVW-1:0] div;
    logic            from_cmd;
    logic            running;
    logic            rise;
    logic            fall;
    logic            scan;

    // A zero-length scan parks in HDR for one cycle without clocking tck.
    assign running = (state == RST_SEQ) || (state == SHIFT) || (state == TRL)
                   || ((state == HDR) && (len_q != '0));
    assign rise  = running && (div == DIV_LAST) && !tck;
    assign fall  = running && (div == DIV_LAST) && tck;
    assign nxt   = idx + ONE;
    assign scan  = (op_q != OP_IDLE);
    assign hdr_n = (op_q == OP_IR) ? LW'(4) : LW'(3);
    assign rsh   = LEN_MAX - len_q;

    always_ff @(posedge iclk) begin
        if (ireset) begin
            state     <= RST_SEQ;
            op_q      <= OP_RST;
            len_q     <= '0;
            idx       <= '0;
            div       <= '0;
            sh_q      <= '0;
            cap       <= '0;
            from_cmd  <= 1'b0;
            tck       <= 1'b0;
            tms       <= 1'b1;
            tdi       <= 1'b0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (running) begin
                div <= (div == DIV_LAST) ? '0 : div + DIV_ONE;
            end
            if (rise) begin
                tck <= 1'b1;
                if ((state == SHIFT) && scan) begin
                    cap <= {tdo, cap[DW-1:1]};
                end
            end
            if (fall) begin
                tck <= 1'b0;
            end
            case (state)
                IDLE: if (cmd_valid && cmd_ready) begin
                    cmd_ready <= 1'b0;
                    busy      <= 1'b1;
                    op_q      <= cmd_op;
                    len_q     <= (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
                    sh_q      <= cmd_data;
                    cap       <= '0;
                    idx       <= '0;
                    div       <= '0;
                    from_cmd  <= (cmd_op == OP_RST);
                    case (cmd_op)
                        OP_RST: begin
                            state <= RST_SEQ;
                            tms   <= 1'b1;
                        end
                        OP_IDLE: begin
                            state <= (cmd_len == '0) ? HDR : SHIFT;
                            tms   <= 1'b0;
                        end
                        default: begin
                            state <= HDR;
                            tms   <= (cmd_len != '0);
                        end
                    endcase
                end
                RST_SEQ: if (fall) begin
                    if (nxt == LW'(6)) begin
                        if (from_cmd) begin
                            state     <= DONE;
                            rsp_valid <= 1'b1;
                            rsp_data  <= '0;
                        end else begin
                            state     <= IDLE;
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                        end
                    end else begin
                        idx <= nxt;
                        tms <= (nxt != LW'(5));
                    end
                end
                HDR: if (len_q == '0) begin
                    state     <= DONE;
                    rsp_valid <= 1'b1;
                    rsp_data  <= '0;
                end else if (fall) begin
                    if (nxt == hdr_n) begin
                        state <= SHIFT;
                        idx   <= '0;
                        tms   <= (len_q == ONE);
                        tdi   <= sh_q[0];
                        sh_q  <= sh_q >> 1;
                    end else begin
                        idx <= nxt;
                        tms <= (op_q == OP_IR) && (nxt == ONE);
                    end
                end
                SHIFT: if (fall) begin
                    if (nxt == len_q) begin
                        tdi <= 1'b0;
                        if (scan) begin
                            state <= TRL;
                            idx   <= '0;
                            tms   <= 1'b1;
                        end else begin
                            state     <= DONE;
                            rsp_valid <= 1'b1;
                            rsp_data  <= '0;
                        end
                    end else begin
                        idx  <= nxt;
                        tms  <= scan && (nxt == len_q - ONE);
                        tdi  <= scan && sh_q[0];
                        sh_q <= sh_q >> 1;
                    end
                end
                TRL: if (fall) begin
                    if (idx == '0) begin
                        idx <= ONE;
                        tms <= 1'b0;
                    end else begin
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                        rsp_data  <= cap >> rsh;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: state <= RST_SEQ;
            endcase
        end
    end
endmodule

// File: tb/tb_jtag_tap_master.sv
// Bench for jtag_tap_master: behavioural target TAP with 4-bit IR and
// 8-bit DR, plus a response queue filled as commands are issued.
module tb_jtag_tap_master;
    logic        iclk = 1'b0;
    logic        ireset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'b00;
    logic [5:0]  cmd_len = '0;
    logic [31:0] cmd_data = '0;
    logic        cmd_ready, rsp_valid, busy, tck, tms, tdi, tdo;
    logic [31:0] rsp_data;

    int tests = 0;
    int fails = 0;

    always #5 iclk = ~iclk;

    jtag_tap_master #(.DW(32), .CLK_DIV(2)) dut (
        .iclk(iclk), .ireset(ireset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
    );

    localparam logic [3:0] TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3;
    localparam logic [3:0] SHDR = 4, EX1DR = 5, PDR = 6, EX2DR = 7;
    localparam logic [3:0] UPDR = 8, SELIR = 9, CAPIR = 10, SHIR = 11;
    localparam logic [3:0] EX1IR = 12, PIR = 13, EX2IR = 14, UPIR = 15;

    function automatic logic [3:0] tap_next(input logic [3:0] s, input logic m);
        case (s)
            TLR:   return m ? TLR   : RTI;
            RTI:   return m ? SELDR : RTI;
            SELDR: return m ? SELIR : CAPDR;
            CAPDR: return m ? EX1DR : SHDR;
            SHDR:  return m ? EX1DR : SHDR;
            EX1DR: return m ? UPDR  : PDR;
            PDR:   return m ? EX2DR : PDR;
            EX2DR: return m ? UPDR  : SHDR;
            UPDR:  return m ? SELDR : RTI;
            SELIR: return m ? TLR   : CAPIR;
            CAPIR: return m ? EX1IR : SHIR;
            SHIR:  return m ? EX1IR : SHIR;
            EX1IR: return m ? UPIR  : PIR;
            PIR:   return m ? EX2IR : PIR;
            EX2IR: return m ? UPIR  : SHIR;
            default: return m ? SELDR : RTI;
        endcase
    endfunction

    logic [3:0] tap_st = RTI;
    logic [7:0] dr_sh = '0, dr_reg = '0;
    logic [3:0] ir_sh = '0, ir_reg = '0;
    logic       tms_hist [0:511];
    int         edges = 0;
    int         tlr_cnt = 0;

    assign tdo = (tap_st == SHDR) ? dr_sh[0] : (tap_st == SHIR) ? ir_sh[0] : 1'b0;

    always @(posedge tck) begin
        case (tap_st)
            CAPDR: dr_sh = 8'hA5;
            SHDR:  dr_sh = {tdi, dr_sh[7:1]};
            UPDR:  dr_reg = dr_sh;
            CAPIR: ir_sh = 4'h1;
            SHIR:  ir_sh = {tdi, ir_sh[3:1]};
            UPIR:  ir_reg = ir_sh;
            default: ;
        endcase
        tap_st = tap_next(tap_st, tms);
        if (tap_st == TLR) tlr_cnt++;
        if (edges < 512) tms_hist[edges] = tms;
        edges++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [31:0] exp_q [$];
    int          rsp_cnt = 0;
    logic        prev_rv = 1'b0;

    always @(negedge iclk) begin
        if (rsp_valid) begin
            rsp_cnt++;
            chk("rsp_pulse_width", 64'(prev_rv), 64'd0);
            chk("rsp_pending", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) chk("rsp_data", 64'(rsp_data), 64'(exp_q.pop_front()));
        end
        prev_rv = rsp_valid;
    end

    task automatic get_pat(input int b, output logic [63:0] p);
        p = '0;
        for (int i = 0; i < 64; i++)
            if (b + i < edges && b + i < 512) p[i] = tms_hist[b + i];
    endtask

    task automatic send(input logic [1:0] op, input int len, input logic [31:0] d);
        int n;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 200) begin
            @(negedge iclk);
            n++;
        end
        chk("ready_wait", 64'(cmd_ready), 64'd1);
        cmd_op = op;
        cmd_len = 6'(len);
        cmd_data = d;
        cmd_valid = 1'b1;
        @(negedge iclk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int c0);
        int n;
        n = 0;
        while (rsp_cnt == c0 && n < 1000) begin
            @(negedge iclk);
            n++;
        end
        chk("rsp_timeout", 64'(rsp_cnt != c0), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    int          b, c0, t0, run, bad, n;
    logic        prev, seen_rise;
    logic [63:0] pat;

    initial begin
        // 1: reset values, then automatic TLR sequence
        repeat (3) @(negedge iclk);
        chk("rst_tck", 64'(tck), 64'd0);
        chk("rst_tms", 64'(tms), 64'd1);
        chk("rst_tdi", 64'(tdi), 64'd0);
        chk("rst_ready", 64'(cmd_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        b = edges;
        t0 = tlr_cnt;
        ireset = 1'b0;
        run = 0; bad = 0; prev = 1'b0; seen_rise = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge iclk);
            if (tck !== prev) begin
                if ((prev || seen_rise) && run != 2) bad++;
                if (tck) seen_rise = 1'b1;
                run = 1;
                prev = tck;
            end else begin
                run++;
            end
        end
        get_pat(b, pat);
        chk("seq_edges", 64'(edges - b), 64'd6);
        chk("seq_tms", pat, 64'h1F);
        chk("seq_phase_len", 64'(bad), 64'd0);
        chk("seq_ready", 64'(cmd_ready), 64'd1);
        chk("seq_busy", 64'(busy), 64'd0);
        chk("seq_tck", 64'(tck), 64'd0);
        chk("seq_tlr", 64'(tlr_cnt > t0), 64'd1);
        chk("seq_tap_rti", 64'(tap_st), 64'(RTI));

        // 2: DR scan 8 bits; a competing command while busy must be ignored
        b = edges; c0 = rsp_cnt;
        exp_q.push_back(32'h0000_00A5);
        send(2'b10, 8, 32'h3C);
        cmd_op = 2'b11; cmd_len = 6'd5; cmd_valid = 1'b1;
        repeat (3) @(negedge iclk);
        cmd_valid = 1'b0;
        wait_rsp(c0);
        get_pat(b, pat);
        chk("dr8_edges", 64'(edges - b), 64'd13);
        chk("dr8_tms", pat, 64'h0C01);
        chk("dr8_update", 64'(dr_reg), 64'h3C);
        chk("dr8_tap_rti", 64'(tap_st), 64'(RTI));

        // 3: IR scan 4 bits
        b = edges; c0 = rsp_cnt;
        exp_q.push_back(32'h0000_0001);
        send(2'b01, 4, 32'h8);
        wait_rsp(c0);
        get_pat(b, pat);
        chk("ir4_edges", 64'(edges - b), 64'd10);
        chk("ir4_tms", pat, 64'h183);
        chk("ir4_update", 64'(ir_reg), 64'h8);
        chk("ir4_tap_rti", 64'(tap_st), 64'(RTI));

        // 4: zero-length DR scan, then 3 idle clocks
        b = edges;
        exp_q.push_back(32'h0);
        send(2'b10, 0, 32'hFFFF_FFFF);
        chk("z_busy", 64'(busy), 64'd1);
        chk("z_ready", 64'(cmd_ready), 64'd0);
        chk("z_rv_early", 64'(rsp_valid), 64'd0);
        @(negedge iclk);
        chk("z_rv", 64'(rsp_valid), 64'd1);
        @(negedge iclk);
        chk("z_rv_end", 64'(rsp_valid), 64'd0);
        chk("z_ready_back", 64'(cmd_ready), 64'd1);
        chk("z_busy_end", 64'(busy), 64'd0);
        chk("z_edges", 64'(edges - b), 64'd0);
        b = edges; c0 = rsp_cnt;
        exp_q.push_back(32'h0);
        send(2'b11, 3, 32'hFFFF_FFFF);
        wait_rsp(c0);
        get_pat(b, pat);
        chk("idle3_edges", 64'(edges - b), 64'd3);
        chk("idle3_tms", pat, 64'h0);
        chk("idle3_tap_rti", 64'(tap_st), 64'(RTI));

        // 5: over-long DR scan clamps to 32 shift bits
        b = edges; c0 = rsp_cnt;
        exp_q.push_back(32'hADBE_EFA5);
        send(2'b10, 40, 32'hDEAD_BEEF);
        wait_rsp(c0);
        get_pat(b, pat);
        chk("dr40_edges", 64'(edges - b), 64'd37);
        chk("dr40_tms", pat, 64'h0000_000C_0000_0001);
        chk("dr40_update", 64'(dr_reg), 64'hDE);
        chk("dr40_tap_rti", 64'(tap_st), 64'(RTI));

        // 6: reset during the third shift bit
        b = edges;
        exp_q.push_back(32'h0000_00A5);
        send(2'b10, 8, 32'hFF);
        exp_q.delete();
        n = 0;
        while (edges < b + 6 && n < 500) begin
            @(negedge iclk);
            n++;
        end
        chk("abort_reach", 64'(edges - b), 64'd6);
        c0 = rsp_cnt;
        ireset = 1'b1;
        @(negedge iclk);
        chk("abort_tck", 64'(tck), 64'd0);
        chk("abort_tms", 64'(tms), 64'd1);
        chk("abort_busy", 64'(busy), 64'd1);
        chk("abort_ready", 64'(cmd_ready), 64'd0);
        repeat (2) @(negedge iclk);
        b = edges;
        t0 = tlr_cnt;
        ireset = 1'b0;
        repeat (60) @(negedge iclk);
        get_pat(b, pat);
        chk("abort_seq_edges", 64'(edges - b), 64'd6);
        chk("abort_seq_tms", pat, 64'h1F);
        chk("abort_no_rsp", 64'(rsp_cnt - c0), 64'd0);
        chk("abort_tlr", 64'(tlr_cnt > t0), 64'd1);
        chk("abort_tap_rti", 64'(tap_st), 64'(RTI));
        chk("abort_ready_back", 64'(cmd_ready), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
